// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector: width math and
// elaboration-time construction of the KMP transition data.
package seq_det_pkg;

    localparam int unsigned MAX_PAT_LEN = 16;
    localparam int unsigned MAX_ST_W    = 4;

    // One next-state entry per matched-prefix length, used when the incoming bit mismatches
    typedef logic [MAX_PAT_LEN-1:0][MAX_ST_W-1:0] kmp_tbl_t;

    // Ceiling log2; callers guarantee v >= 2
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Pattern bit in arrival order: index 0 is the first bit received (the MSB)
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat,
                                     input int unsigned            len,
                                     input int unsigned            i);
        return pat[4'(len - 1 - i)];
    endfunction

    // Pattern rearranged so that bit i is the i-th bit expected on the wire
    function automatic logic [MAX_PAT_LEN-1:0] arrival_order(input logic [MAX_PAT_LEN-1:0] pat,
                                                             input int unsigned            len);
        logic [MAX_PAT_LEN-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < len; i++) begin
            r[4'(i)] = pat_bit(pat, len, i);
        end
        return r;
    endfunction

    // Longest proper pattern prefix that is a suffix of (first k pattern bits, then b)
    function automatic int unsigned border(input logic [MAX_PAT_LEN-1:0] pat,
                                           input int unsigned            len,
                                           input int unsigned            k,
                                           input logic                   b);
        int unsigned n;
        int unsigned best;
        int unsigned idx;
        logic        ok;
        logic        sb;
        n    = k + 1;
        best = 0;
        for (int unsigned l = 1; (l < len) && (l <= n); l++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < l; j++) begin
                idx = n - l + j;
                sb  = (idx < k) ? pat_bit(pat, len, idx) : b;
                if (sb != pat_bit(pat, len, j)) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                best = l;
            end
        end
        return best;
    endfunction

    // Next state for every k when the received bit is the complement of the expected one
    function automatic kmp_tbl_t build_mismatch_tbl(input logic [MAX_PAT_LEN-1:0] pat,
                                                    input int unsigned            len);
        kmp_tbl_t t;
        t = '0;
        for (int unsigned k = 0; k < len; k++) begin
            t[4'(k)] = MAX_ST_W'(border(pat, len, k, ~pat_bit(pat, len, k)));
        end
        return t;
    endfunction

    // F(len): state to resume from after a full match when overlaps are counted
    function automatic int unsigned full_border(input logic [MAX_PAT_LEN-1:0] pat,
                                                input int unsigned            len);
        return border(pat, len, len - 1, pat_bit(pat, len, len - 1));
    endfunction

endpackage

// File: rtl/seq_detector_param_counter.sv
// Saturating match counter with a sticky saturation flag; clear beats increment.
module seq_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    // Next count: clear first, otherwise bump unless already at all-ones
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && !(&count_q)) begin
                count_d = count_q + CNT_W'(1);
            end
            sat_d = sat_q | (&count_d);
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector built on an elaboration-time KMP automaton.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1010,
    parameter bit                   OVERLAP = 1'b1,
    parameter bit                   REG_OUT = 1'b0,
    parameter int unsigned          CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             valid,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int unsigned ST_W = clog2(PAT_LEN);

    localparam logic [MAX_PAT_LEN-1:0] PAT_ORD = arrival_order(MAX_PAT_LEN'(PATTERN), PAT_LEN);
    localparam kmp_tbl_t               MIS_TBL = build_mismatch_tbl(MAX_PAT_LEN'(PATTERN), PAT_LEN);

    // Encodings at or above PAT_LEN are unreachable and are steered back to idle
    localparam logic [MAX_PAT_LEN:0]   LIVE_W  = ((MAX_PAT_LEN + 1)'(1) << PAT_LEN) - (MAX_PAT_LEN + 1)'(1);
    localparam logic [MAX_PAT_LEN-1:0] LIVE    = LIVE_W[MAX_PAT_LEN-1:0];

    localparam logic [ST_W-1:0] S_IDLE = '0;
    localparam logic [ST_W-1:0] S_LAST = ST_W'(PAT_LEN - 1);
    localparam logic [ST_W-1:0] S_FULL = ST_W'(full_border(MAX_PAT_LEN'(PATTERN), PAT_LEN));

    logic [ST_W-1:0] state_q, state_d;
    logic            z_q, z_d;
    logic            match_c;
    logic            exp_bit;

    assign exp_bit = PAT_ORD[4'(state_q)];

    // Next state and Mealy match from matched-prefix length and the incoming bit
    always_comb begin
        state_d = state_q;
        match_c = 1'b0;
        if (!LIVE[4'(state_q)]) begin
            state_d = S_IDLE;
        end else if (valid) begin
            if (x == exp_bit) begin
                if (state_q == S_LAST) begin
                    match_c = 1'b1;
                    state_d = OVERLAP ? S_FULL : S_IDLE;
                end else begin
                    state_d = state_q + ST_W'(1);
                end
            end else begin
                state_d = ST_W'(MIS_TBL[4'(state_q)]);
            end
        end
        z_d = match_c;
    end

    // State and delayed-match registers; reset drops any partial match
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign z = REG_OUT ? z_q : match_c;

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_c),
        .clr   (clr_cnt),
        .count (match_count),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: several parameterisations driven in parallel,
// checked against a sliding-window reference model.
module tb_seq_detector_param;

    localparam int NI = 7;
    localparam int          M_LEN [NI] = '{4, 4, 3, 3, 4, 4, 6};
    localparam logic [15:0] M_PAT [NI] = '{16'b1010, 16'b1010, 16'b111, 16'b111,
                                          16'b1010, 16'b1010, 16'b110110};
    localparam int          M_OV  [NI] = '{1, 0, 1, 0, 1, 1, 1};
    localparam int          M_RG  [NI] = '{0, 0, 0, 0, 1, 0, 1};
    localparam int          M_CW  [NI] = '{8, 8, 8, 8, 8, 2, 4};

    logic clk;
    logic reset;
    logic x;
    logic valid;
    logic clr_cnt;

    logic       z0, z1, z2, z3, z4, z5, z6;
    logic       s0, s1, s2, s3, s4, s5, s6;
    logic [7:0] c0, c1, c2, c3, c4;
    logic [1:0] c5;
    logic [3:0] c6;

    logic       z_a [NI];
    logic       s_a [NI];
    logic [7:0] c_a [NI];

    int n_vec;
    int n_err;

    // Reference model state
    logic [15:0] m_hist [NI];
    int          m_n    [NI];
    int          m_cnt  [NI];
    logic        m_sat  [NI];
    logic        m_zr   [NI];
    logic        m_now  [NI];

    initial clk = 1'b1;
    always #5 clk = ~clk;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .REG_OUT(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z0), .match_count(c0), .cnt_sat(s0));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0), .REG_OUT(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z1), .match_count(c1), .cnt_sat(s1));
    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1), .REG_OUT(1'b0), .CNT_W(8)) u2 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z2), .match_count(c2), .cnt_sat(s2));
    seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0), .REG_OUT(1'b0), .CNT_W(8)) u3 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z3), .match_count(c3), .cnt_sat(s3));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .REG_OUT(1'b1), .CNT_W(8)) u4 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z4), .match_count(c4), .cnt_sat(s4));
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1), .REG_OUT(1'b0), .CNT_W(2)) u5 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z5), .match_count(c5), .cnt_sat(s5));
    seq_detector_param #(.PAT_LEN(6), .PATTERN(6'b110110), .OVERLAP(1'b1), .REG_OUT(1'b1), .CNT_W(4)) u6 (
        .clk(clk), .reset(reset), .x(x), .valid(valid), .clr_cnt(clr_cnt), .z(z6), .match_count(c6), .cnt_sat(s6));

    // Gather per-instance outputs into arrays
    always_comb begin
        z_a[0] = z0; z_a[1] = z1; z_a[2] = z2; z_a[3] = z3; z_a[4] = z4; z_a[5] = z5; z_a[6] = z6;
        s_a[0] = s0; s_a[1] = s1; s_a[2] = s2; s_a[3] = s3; s_a[4] = s4; s_a[5] = s5; s_a[6] = s6;
        c_a[0] = c0; c_a[1] = c1; c_a[2] = c2; c_a[3] = c3; c_a[4] = c4;
        c_a[5] = 8'(c5);
        c_a[6] = 8'(c6);
    end

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s[u%0d] observed=%0d expected=%0d", tag, idx, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_hist[i] = '0;
            m_n[i]    = 0;
            m_cnt[i]  = 0;
            m_sat[i]  = 1'b0;
            m_zr[i]   = 1'b0;
            m_now[i]  = 1'b0;
        end
    endtask

    // A match is the last PAT_LEN valid bits (since the last restart) equalling the pattern
    task automatic model_eval();
        logic [15:0] cand;
        logic [16:0] m17;
        logic [15:0] mask;
        for (int i = 0; i < NI; i++) begin
            cand     = {m_hist[i][14:0], x};
            m17      = (17'(1) << M_LEN[i]) - 17'(1);
            mask     = m17[15:0];
            m_now[i] = valid && ((m_n[i] + 1) >= M_LEN[i]) && ((cand & mask) == (M_PAT[i] & mask));
        end
    endtask

    task automatic model_commit();
        int cmax;
        for (int i = 0; i < NI; i++) begin
            cmax = (1 << M_CW[i]) - 1;
            if (valid) begin
                m_hist[i] = {m_hist[i][14:0], x};
                m_n[i]    = m_n[i] + 1;
                if (m_now[i] && (M_OV[i] == 0)) begin
                    m_n[i] = 0;
                end
            end
            if (clr_cnt) begin
                m_cnt[i] = 0;
                m_sat[i] = 1'b0;
            end else if (m_now[i] && (m_cnt[i] < cmax)) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            if (m_cnt[i] == cmax) begin
                m_sat[i] = 1'b1;
            end
            m_zr[i] = m_now[i];
        end
    endtask

    task automatic check_all();
        logic ez;
        for (int i = 0; i < NI; i++) begin
            ez = (M_RG[i] != 0) ? m_zr[i] : m_now[i];
            chk("z", i, 32'(z_a[i]), 32'(ez));
            chk("match_count", i, 32'(c_a[i]), 32'(m_cnt[i]));
            chk("cnt_sat", i, 32'(s_a[i]), 32'(m_sat[i]));
        end
    endtask

    // One clock of stimulus; entered and left just after a rising edge
    task automatic step(input logic bx, input logic bv, input logic bc);
        x       = bx;
        valid   = bv;
        clr_cnt = bc;
        model_eval();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(bits[i], 1'b1, 1'b0);
        end
    endtask

    // Reset pulse placed between clock edges, outputs checked while it is held
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset   = 1'b1;
        valid   = 1'b0;
        clr_cnt = 1'b0;
        #1;
        model_reset();
        model_eval();
        check_all();
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset   = 1'b1;
        x       = 1'b0;
        valid   = 1'b0;
        clr_cnt = 1'b0;
        model_reset();
        model_eval();
        #3;
        check_all();
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Overlap versus restart on the reference stream
        stream(16'b001010100110, 12);
        chk("dir_ovl_count", 0, 32'(c_a[0]), 32'd2);
        chk("dir_novl_count", 1, 32'(c_a[1]), 32'd1);

        // Run of ones against 111
        async_reset();
        stream(16'b11111, 5);
        chk("dir_111_ovl", 2, 32'(c_a[2]), 32'd3);
        chk("dir_111_novl", 3, 32'(c_a[3]), 32'd1);

        // Gaps in valid with x toggling must not disturb the partial match
        async_reset();
        stream(16'b101, 3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("dir_gap_mealy", 0, 32'(c_a[0]), 32'd1);
        chk("dir_gap_reg", 4, 32'(c_a[4]), 32'd1);

        // Saturation of a 2-bit counter, then clear colliding with a match
        async_reset();
        for (int r = 0; r < 5; r++) begin
            stream(16'b10100, 5);
        end
        chk("dir_sat_count", 5, 32'(c_a[5]), 32'd3);
        chk("dir_sat_flag", 5, 32'(s_a[5]), 32'd1);
        stream(16'b101, 3);
        step(1'b0, 1'b1, 1'b1);
        chk("dir_clr_count", 5, 32'(c_a[5]), 32'd0);
        chk("dir_clr_flag", 5, 32'(s_a[5]), 32'd0);

        // Reset in the middle of a partial match discards it
        async_reset();
        stream(16'b101, 3);
        async_reset();
        step(1'b0, 1'b1, 1'b0);
        chk("dir_rst_nomatch", 0, 32'(c_a[0]), 32'd0);
        stream(16'b1010, 4);
        chk("dir_rst_match", 0, 32'(c_a[0]), 32'd1);

        // Random traffic with sparse clears and resets
        for (int t = 0; t < 900; t++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                step(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 39) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the team's fixed 4-bit "1010" Mealy detector.
- Watches a 1-bit serial stream and flags every occurrence of a compile-time pattern of any length.
- Selectable overlap mode and Mealy/registered output timing, plus a saturating match counter.
- Sits at the serial front end, feeding frame-sync and statistics logic.

Parameters:
- PAT_LEN, 4: pattern length in bits, 2..16.
- PATTERN, 4'b1010: pattern value, PAT_LEN bits. The MSB is the first bit received.
- OVERLAP, 1: 1 = overlapping matches are counted; 0 = the search restarts from scratch after each match.
- REG_OUT, 0: 0 = Mealy output, combinational from state and x; 1 = z registered, one cycle later.
- CNT_W, 8: width of the match counter.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- x, input, 1: serial data bit.
- valid, input, 1: x is sampled only on cycles where valid=1.
- clr_cnt, input, 1: synchronous clear of match_count and cnt_sat.
- z, output, 1: match pulse.
- match_count, output, CNT_W: number of matches, saturating.
- cnt_sat, output, 1: sticky flag, set when match_count reaches all-ones.

Behaviour:
- Reset: state=0, match_count=0, cnt_sat=0, registered z=0. Reset is asynchronous and takes effect mid-stream; any partial match is discarded.
- State encoding: state k (0..PAT_LEN-1) = number of pattern bits matched so far, MSB first. State register width is clog2(PAT_LEN).
- Next state on a valid bit b from state k:
  - If b == PATTERN[PAT_LEN-1-k] and k < PAT_LEN-1: next state = k+1.
  - If k == PAT_LEN-1 and b matches: full match. Next state = F(PAT_LEN) when OVERLAP=1, else 0.
  - On mismatch: next state = the longest proper prefix of PATTERN that is a suffix of (the k matched bits followed by b). This is the KMP automaton.
  - F(n) is the longest proper prefix of PATTERN that is also a suffix of its first n bits.
- Transition tables: computed at elaboration by a constant function. No runtime search logic.
- valid=0: state holds, z=0 and no count update. x is don't-care on these cycles.
- Match condition: match = valid & (state==PAT_LEN-1) & (x==PATTERN[0]).
- z timing:
  - REG_OUT=0: z = match, combinational, same cycle as the last pattern bit.
  - REG_OUT=1: z is match registered, asserted for exactly one cycle in the cycle after the last bit. Latency is 1.
- match_count: increments by 1 on each match and saturates at 2^CNT_W-1. cnt_sat goes to 1 in the same edge that the count reaches all-ones, and stays set until clr_cnt or reset.
- clr_cnt and a match in the same cycle: clear wins, so the count becomes 0, not 1. z is unaffected by clr_cnt.
- Simultaneous match while saturated: count holds and z still pulses.
- No latches: the next-state/output block is fully assigned for all state values. Unused encodings go to 0.

Decomposition:
- Shared package/include seq_det_pkg:
  - clog2 function.
  - Constant function building the next-on-mismatch table and F(PAT_LEN) from PATTERN and PAT_LEN.
  - Localparam for the state width.
- Sub-module seq_match_counter (parameter CNT_W): inputs inc and clr; outputs count and sat. Saturating counter with clear priority.
- The FSM and output stage stay in seq_detector_param.

Test Plan:
- Default parameters (1010, OVERLAP=1, REG_OUT=0), reset for 15 ns, valid=1. Stream 0,0,1,0,1,0,1,0,0,1,1,0 -> z high on bits 6 and 8 only; match_count=2.
- Same stream with OVERLAP=0 -> z high on bit 6 only; match_count=1.
- PATTERN=3'b111, PAT_LEN=3, OVERLAP=1, stream 1,1,1,1,1 -> z on bits 3, 4 and 5; count=3. With OVERLAP=0 -> z on bit 3 only; count=1.
- Default parameters, stream 1,0,1 then valid=0 for 3 cycles with x toggling, then 0 with valid=1 -> exactly one z pulse, on the final valid bit. Repeat with REG_OUT=1 -> the pulse appears one cycle later and is one cycle wide.
- CNT_W=2, feed 5 non-overlapping 1010 patterns -> count 1,2,3,3,3; cnt_sat rises with the 3rd match; z pulses all 5 times. Then clr_cnt together with a 6th match -> count=0, cnt_sat=0.
- Stream 1,0,1, assert reset asynchronously between clock edges, release, then send 0 -> no match. Then 1,0,1,0 -> match; all outputs read 0 during reset.
